// File: rtl/vram_arbiter_if.sv
// Purpose : groups the drawing-engine write port and the single-port RAM port
//           used by vram_arbiter.
// Latency : none (signal bundle only).
// Backpressure: wr_ack is the only flow control; the requester holds
//           wr_addr/wr_data while wr_req is high and no ack has been given.
// Ports   : wr_req/wr_addr/wr_data -> arbiter, wr_ack/wr_err <- arbiter,
//           mem_addr/mem_we/mem_wdata -> RAM, mem_rdata <- RAM.
interface vram_arbiter_if;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  // Environment side: drawing engine plus the RAM model.
  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, wr_err, mem_addr, mem_we, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, wr_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Purpose : shares one single-port framebuffer RAM between the VGA scan-out
//           (one fetch per 4 screen pixels) and a drawing engine write port.
// Latency : RAM address/we/wdata and wr_ack are combinational in the slot
//           cycle; (h,v) to pix_out/pix_valid is 2 dclk.
// Backpressure: display fetches always win; a write request landing on a
//           display slot simply gets no ack and is served in the next write
//           slot. Out-of-range writes are acked, dropped and flag wr_err.
// Ports   : dclk, clr (async, active-high), vid_active/h/v from the timing
//           generator, bus (vram_arbiter_if.slave), pix_out/pix_valid to VGA.
module vram_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic           dclk,
  input  logic           clr,
  input  logic           vid_active,
  input  logic [9:0]     h,
  input  logic [9:0]     v,
  vram_arbiter_if.slave  bus,
  output logic [7:0]     pix_out,
  output logic           pix_valid
);

  localparam int FB_SIZE = FB_W * FB_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DISP  = 2'd1,
    WRITE = 2'd2,
    DROP  = 2'd3
  } state_t;

  // state is the decision for the current cycle (outputs are combinational
  // in the slot cycle); state_q remembers last cycle's decision so the
  // pixel register knows when mem_rdata carries a display fetch.
  state_t      state;
  state_t      state_q;

  // en_q goes high on the first dclk edge after clr falls, so release of
  // reset takes effect on a clock edge rather than mid-cycle.
  logic        en_q;

  logic [14:0] addr_q;
  logic [7:0]  wdata_q;
  logic        err_q;
  logic [7:0]  pix_q;
  logic        va1_q;
  logic        va2_q;

  logic [14:0] row;
  logic [14:0] col;
  logic [14:0] disp_addr;
  logic        disp_slot;
  logic        in_range;

  logic [14:0] mem_addr_c;
  logic        mem_we_c;
  logic [7:0]  mem_wdata_c;
  logic        wr_ack_c;

  // ---------------------------------------------------------------------
  // Display address: framebuffer row/column of the screen pixel.
  // ---------------------------------------------------------------------
  assign row = 15'(v >> SCALE_LOG2);
  assign col = 15'(h >> SCALE_LOG2);

  generate
    if (FB_W == 160) begin : g_mul160
      // row*160 as row*128 + row*32; max 119*160+159 = 19199 fits 15 bits.
      assign disp_addr = (row << 7) + (row << 5) + col;
    end else begin : g_mul_generic
      assign disp_addr = 15'(row * FB_W) + col;
    end
  endgenerate

  // One display slot per group of 2**SCALE_LOG2 active pixels.
  assign disp_slot = vid_active && (h[SCALE_LOG2-1:0] == '0);
  assign in_range  = 32'(bus.wr_addr) < FB_SIZE;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      en_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      en_q    <= 1'b1;
      state_q <= state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: per-cycle decision and RAM/ack outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state       = IDLE;
    mem_addr_c  = addr_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = wdata_q;
    wr_ack_c    = 1'b0;

    // No request is looked at until reset release has reached a clock edge;
    // a write caught by clr is therefore re-arbitrated from scratch.
    if (en_q) begin
      if (disp_slot) begin
        state = DISP;
      end else if (bus.wr_req) begin
        state = in_range ? WRITE : DROP;
      end
    end

    case (state)
      DISP: begin
        mem_addr_c = disp_addr;
      end
      WRITE: begin
        mem_addr_c  = bus.wr_addr;
        mem_wdata_c = bus.wr_data;
        mem_we_c    = 1'b1;
        wr_ack_c    = 1'b1;
      end
      DROP: begin
        wr_ack_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.wr_ack    = wr_ack_c;
  // Raised in the dropping cycle itself, then held by err_q until clr.
  assign bus.wr_err    = err_q | (state == DROP);

  // ---------------------------------------------------------------------
  // Held RAM outputs, sticky error, pixel pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      pix_q   <= '0;
      va1_q   <= 1'b0;
      va2_q   <= 1'b0;
    end else begin
      addr_q  <= mem_addr_c;
      wdata_q <= mem_wdata_c;
      if (state == DROP) begin
        err_q <= 1'b1;
      end
      // mem_rdata now answers the address issued in last cycle's DISP slot.
      if (state_q == DISP) begin
        pix_q <= bus.mem_rdata;
      end
      // Gated with en_q so pix_valid stays low for two cycles after release.
      va1_q <= vid_active & en_q;
      va2_q <= va1_q;
    end
  end

  assign pix_valid = va2_q;
  assign pix_out   = va2_q ? pix_q : 8'h00;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- SCALE_LOG2, 2, each framebuffer pixel is replicated 4x4 on the 640x480 screen.

REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- dclk, in, 1, pixel clock (25 MHz).
- clr, in, 1, reset; asynchronous, active-high.
- vid_active, in, 1, high when (h,v) is inside the 640x480 active area.
- h, in, 10, active-area column (0..639).
- v, in, 10, active-area row (0..479).
- wr_req, in, 1, write request from the drawing engine.
- wr_addr, in, 15, linear framebuffer address.
- wr_data, in, 8, RGB332 pixel to write.
- wr_ack, out, 1, one-cycle pulse; write was issued this cycle.
- wr_err, out, 1, sticky flag; an out-of-range write was dropped.
- mem_addr, out, 15, single-port RAM address.
- mem_we, out, 1, single-port RAM write enable.
- mem_wdata, out, 8, single-port RAM write data.
- mem_rdata, in, 8, RAM read data; valid one cycle after the address.
- pix_out, out, 8, RGB332 pixel to the VGA output stage.
- pix_valid, out, 1, pix_out is an active pixel.

Function
REQ-003 The RAM SHALL be shared on a per-cycle basis. A display slot SHALL be any cycle with vid_active=1 and h[1:0]=0. Every other cycle SHALL be a write slot.
REQ-004 FSM states SHALL be IDLE, DISP, WRITE and DROP; the state SHALL be evaluated each cycle. A display slot SHALL select DISP. A write slot with wr_req=1 and wr_addr<FB_W*FB_H SHALL select WRITE. A write slot with wr_req=1 and wr_addr>=19200 SHALL select DROP. Any other cycle SHALL select IDLE.
REQ-005 In DISP, the outputs SHALL be combinational from the current inputs: mem_addr=(v>>2)*160+(h>>2), mem_we=0. The product SHALL be formed as (v>>2)*128+(v>>2)*32, computed in 15 bits with no overflow (maximum 19199).
REQ-006 In WRITE, the outputs SHALL be mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1 and wr_ack=1, all in the same cycle.
REQ-007 In DROP, the outputs SHALL be mem_we=0 and wr_ack=1, and wr_err SHALL be set; wr_err SHALL clear only on clr.
REQ-008 In IDLE, the outputs SHALL be mem_we=0 and wr_ack=0, with mem_addr holding its last value.
REQ-009 A display slot SHALL always win. A wr_req coinciding with a display slot SHALL wait, with no ack, and SHALL be served in the next write slot.
REQ-010 The requester SHALL hold wr_addr and wr_data stable while wr_req=1 and no ack has been given. wr_req still high in the cycle after an ack SHALL be treated as a new request. Back-to-back acks in consecutive write slots SHALL be permitted.
REQ-011 Read data SHALL be captured into the pixel register in the cycle after a DISP cycle.
REQ-012 pix_out SHALL equal the pixel register when the 2-cycle-delayed vid_active is 1, and 0 otherwise. pix_valid SHALL equal vid_active delayed by 2 cycles. Total latency from (h,v) to pix_out SHALL be 2 dclk; the top level delays the syncs to match.
REQ-013 Guaranteed write bandwidth SHALL be 3 of every 4 cycles during active video and every cycle during blanking.
REQ-014 A write whose request falls on a wrap from h=639 to the next line SHALL follow the normal slot rule, with no special casing.

Reset
REQ-015 While clr=1, the following SHALL be 0: state (IDLE), mem_addr, mem_we, mem_wdata, wr_ack, wr_err, the pixel register, both vid_active delay stages, pix_out and pix_valid.
REQ-016 clr asserted mid-write SHALL abort the write with no ack. The request SHALL be re-arbitrated after clr deasserts, in the first write slot.
REQ-017 Release of clr SHALL take effect on the first dclk rising edge after deassertion.

Verification
REQ-018 Display fetch: with vid_active=1, v=5 and h stepping 0..7 -> mem_addr=160 at h=0 and 161 at h=4. With mem_rdata=0xA5 returned for address 160, pix_out=0xA5 for 4 cycles starting 2 cycles after h=0.
REQ-019 Collision: wr_req=1, wr_addr=100, wr_data=0x3C raised at h=4 (a display slot) -> no ack at h=4; ack at h=5 with mem_we=1, mem_addr=100, mem_wdata=0x3C.
REQ-020 Blanking burst: vid_active=0 and wr_req held high for 10 cycles with new address/data each cycle -> 10 consecutive acks and 10 RAM writes.
REQ-021 Out of range: wr_addr=19200 -> wr_ack pulses, mem_we=0 and wr_err=1. wr_err stays 1 through later valid writes until clr.
REQ-022 Reset: clr pulsed while in WRITE with vid_active=1 -> all outputs 0 during clr. After release, the pending write is acked once, and pix_valid stays 0 for the first 2 cycles.
REQ-023 Boundary: v=479, h=636 -> mem_addr=19199. vid_active falling -> pix_valid falls exactly 2 cycles later.
